// File: rtl/audio_pkg.sv
// Shared audio constants and the PWM decoder state type.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 16;

  localparam logic [SAMPLE_W-1:0] SAMPLE_FULL = 16'hFFFF;
  localparam logic [SAMPLE_W-1:0] SAMPLE_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW
  } pwm_dec_state_t;

endpackage

// File: rtl/pwm_sample_decode_if.sv
// PWM decoder bus: 1-bit PWM line in, decoded sample and status strobes out.
interface pwm_sample_decode_if #(
  parameter int unsigned CNT_W = 14
);
  import audio_pkg::*;

  logic                sig;
  logic [SAMPLE_W-1:0] sample;
  logic [CNT_W-1:0]    period;
  logic [CNT_W-1:0]    high_len;
  logic                valid;
  logic                stuck;
  logic                ovr;

  // PWM source / result consumer side
  modport master (
    output sig,
    input  sample, period, high_len, valid, stuck, ovr
  );

  // Decoder side
  modport slave (
    input  sig,
    output sample, period, high_len, valid, stuck, ovr
  );

endinterface

// File: rtl/duty_divider.sv
// Restoring radix-2 divider: quo = floor(num * 2^16 / den), requires num < den.
// The first quotient bit is resolved in the load cycle, so done rises 16 cycles
// after start and the result is stable while done is high.
module duty_divider
  import audio_pkg::*;
#(
  parameter int unsigned CNT_W = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    num,
  input  logic [CNT_W-1:0]    den,
  output logic                busy,
  output logic                done,
  output logic [SAMPLE_W-1:0] quo
);

  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] den_q;
  logic [3:0]       left_q;

  logic                load;
  logic [CNT_W-1:0]    den_c;
  logic [CNT_W-1:0]    rem_src;
  logic [CNT_W:0]      rem_sh;
  logic                take;
  logic [CNT_W-1:0]    rem_n;
  logic [SAMPLE_W-1:0] quo_n;

  assign load = start && !busy;

  // One restoring step: shift remainder, subtract divisor when it fits
  always_comb begin
    den_c   = load ? den : den_q;
    rem_src = load ? num : rem_q;
    rem_sh  = {rem_src, 1'b0};
    take    = (rem_sh >= {1'b0, den_c});
    rem_n   = take ? CNT_W'(rem_sh - {1'b0, den_c}) : CNT_W'(rem_sh);
    quo_n   = load ? {{(SAMPLE_W-1){1'b0}}, take} : {quo[SAMPLE_W-2:0], take};
  end

  // Iteration control and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      quo    <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      left_q <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        busy   <= 1'b1;
        rem_q  <= rem_n;
        quo    <= quo_n;
        den_q  <= den;
        left_q <= 4'd14;
      end else if (busy) begin
        rem_q <= rem_n;
        quo   <= quo_n;
        if (left_q == 4'd0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          left_q <= left_q - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_sample_decode.sv
// PWM receive decoder: measures high time and period of each PWM cycle and
// reports the normalised duty as a 16-bit sample, 17 cycles after each rise.
// Optional: define PWM_DECODE_GLITCH_FILTER_EN for a 3-sample majority filter
// on the synchronised input (rejects 1-cycle pulses, +2 cycles edge latency).
module pwm_sample_decode
  import audio_pkg::*;
#(
  parameter int unsigned CNT_W       = 14,
  parameter int unsigned TIMEOUT     = 16383,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst,
  pwm_sample_decode_if.slave bus
);

  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_raw;
  logic                   s;
  logic                   s_q;
  logic                   rise;
  logic                   fall;

  pwm_dec_state_t   state_q, state_n;
  logic [CNT_W-1:0] hcnt_q, hcnt_n;
  logic [CNT_W-1:0] pcnt_q, pcnt_n;
  logic [CNT_W-1:0] wcnt_q, wcnt_n;
  logic             timeout_c;
  logic             start_c;
  logic             drop_c;

  logic [CNT_W-1:0]    req_p_q;
  logic [CNT_W-1:0]    req_h_q;
  logic                div_busy;
  logic                div_done;
  logic [SAMPLE_W-1:0] div_quo;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= TMO) ? v : v + ONE;
  endfunction

  // Input synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sig};
  end

  assign s_raw = sync_q[SYNC_STAGES-1];

`ifdef PWM_DECODE_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;

  // 3-sample majority vote over the synchronised line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], s_raw};
      filt_q <= (s_raw & hist_q[0]) | (s_raw & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end
  end

  assign s = filt_q;
`else
  assign s = s_raw;
`endif

  // Edge-detect delay flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_q <= 1'b0;
    else     s_q <= s;
  end

  assign rise = s & ~s_q;
  assign fall = ~s & s_q;

  // FSM and measurement counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_RISE;
      hcnt_q  <= '0;
      pcnt_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_n;
      hcnt_q  <= hcnt_n;
      pcnt_q  <= pcnt_n;
      wcnt_q  <= wcnt_n;
    end
  end

  // Next state, counters, timeout detection and divider request
  always_comb begin
    state_n   = state_q;
    hcnt_n    = hcnt_q;
    pcnt_n    = pcnt_q;
    wcnt_n    = wcnt_q;
    timeout_c = 1'b0;
    start_c   = 1'b0;
    drop_c    = 1'b0;
    case (state_q)
      WAIT_RISE: begin
        hcnt_n = '0;
        pcnt_n = '0;
        if (wcnt_q >= TMO_M1) begin
          timeout_c = 1'b1;
          wcnt_n    = '0;
        end else begin
          wcnt_n = wcnt_q + ONE;
          if (rise) begin
            hcnt_n  = ONE;
            pcnt_n  = ONE;
            state_n = MEAS_HIGH;
          end
        end
      end
      MEAS_HIGH: begin
        if (pcnt_q >= TMO) begin
          timeout_c = 1'b1;
          state_n   = WAIT_RISE;
          hcnt_n    = '0;
          pcnt_n    = '0;
          wcnt_n    = '0;
        end else if (fall) begin
          pcnt_n  = sat_inc(pcnt_q);
          state_n = MEAS_LOW;
        end else begin
          hcnt_n = sat_inc(hcnt_q);
          pcnt_n = sat_inc(pcnt_q);
        end
      end
      MEAS_LOW: begin
        if (pcnt_q >= TMO) begin
          timeout_c = 1'b1;
          state_n   = WAIT_RISE;
          hcnt_n    = '0;
          pcnt_n    = '0;
          wcnt_n    = '0;
        end else if (rise) begin
          start_c = !div_busy;
          drop_c  = div_busy;
          hcnt_n  = ONE;
          pcnt_n  = ONE;
          state_n = MEAS_HIGH;
        end else begin
          pcnt_n = sat_inc(pcnt_q);
        end
      end
      default: begin
        state_n = WAIT_RISE;
        hcnt_n  = '0;
        pcnt_n  = '0;
        wcnt_n  = '0;
      end
    endcase
  end

  duty_divider #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (start_c),
    .num   (hcnt_q),
    .den   (pcnt_q),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_quo)
  );

  // Output registers; a timeout result overrides a divider result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sample   <= SAMPLE_ZERO;
      bus.period   <= '0;
      bus.high_len <= '0;
      bus.valid    <= 1'b0;
      bus.stuck    <= 1'b0;
      bus.ovr      <= 1'b0;
      req_p_q      <= '0;
      req_h_q      <= '0;
    end else begin
      bus.valid <= 1'b0;
      bus.stuck <= 1'b0;
      bus.ovr   <= drop_c;
      if (timeout_c) begin
        bus.valid  <= 1'b1;
        bus.stuck  <= 1'b1;
        bus.sample <= s ? SAMPLE_FULL : SAMPLE_ZERO;
      end else if (div_done) begin
        bus.valid    <= 1'b1;
        bus.sample   <= div_quo;
        bus.period   <= req_p_q;
        bus.high_len <= req_h_q;
      end
      if (start_c) begin
        req_p_q <= pcnt_q;
        req_h_q <= hcnt_q;
      end
    end
  end

endmodule
